// File: rtl/stb_pkg.sv
// Shared types, constants and helpers for the store buffer.
// The entry layout is sized by the STB_AW / STB_DW defaults below.
package stb_pkg;

    localparam int STB_DEPTH = 4;
    localparam int STB_AW    = 32;
    localparam int STB_DW    = 32;
    localparam int PTR_W     = $clog2(STB_DEPTH) + 1;
    localparam int BE_W      = STB_DW / 8;

    typedef struct packed {
        logic                valid;
        logic [STB_AW-3:0]   waddr;
        logic [STB_DW-1:0]   data;
        logic [BE_W-1:0]     be;
    } stb_entry_t;

    // Word address of a byte address (drops the byte offset).
    function automatic logic [STB_AW-3:0] word_addr(input logic [STB_AW-1:0] addr);
        return addr[STB_AW-1:2];
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Core-side and memory-side signals of the store buffer.
// slave: the store buffer itself; master: the MEM stage plus data memory.
interface store_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cpu_we;
    logic            cpu_re;
    logic [AW-1:0]   cpu_addr;
    logic [DW-1:0]   cpu_wdata;
    logic [DW/8-1:0] cpu_be;
    logic            cpu_fence;
    logic [DW-1:0]   cpu_rdata;
    logic            stall_o;
    logic [AW-1:0]   mem_raddr;
    logic [DW-1:0]   mem_rdata;
    logic            mem_wvalid;
    logic            mem_wready;
    logic [AW-1:0]   mem_waddr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wbe;

    modport slave (
        input  cpu_we, cpu_re, cpu_addr, cpu_wdata, cpu_be, cpu_fence,
        input  mem_rdata, mem_wready,
        output cpu_rdata, stall_o, mem_raddr,
        output mem_wvalid, mem_waddr, mem_wdata, mem_wbe
    );

    modport master (
        output cpu_we, cpu_re, cpu_addr, cpu_wdata, cpu_be, cpu_fence,
        output mem_rdata, mem_wready,
        input  cpu_rdata, stall_o, mem_raddr,
        input  mem_wvalid, mem_waddr, mem_wdata, mem_wbe
    );

endinterface

// File: rtl/store_buffer_match.sv
// stb_match: load-address lookup against the buffered stores.
// Reports a hit and, when STB_FWD_EN is defined, the youngest matching
// entry and whether it covers the full word (fwd_ok).
module stb_match
    import stb_pkg::*;
#(
    parameter int DEPTH = STB_DEPTH
) (
    input  stb_entry_t               entries [DEPTH],
    input  logic [$clog2(DEPTH):0]   wr_ptr,
    input  logic [$clog2(DEPTH):0]   rd_ptr,
    input  logic [STB_AW-3:0]        load_waddr,
    output logic                     hit,
`ifdef STB_FWD_EN
    output logic [$clog2(DEPTH)-1:0] match_idx,
`endif
    output logic                     fwd_ok
);

    localparam int IW = $clog2(DEPTH);

    logic [IW:0]   count;
    logic [IW-1:0] idx;
`ifdef STB_FWD_EN
    logic [IW-1:0] youngest;
`endif

    assign count = wr_ptr - rd_ptr;

    // Walk from the newest entry (wr_ptr-1) back towards the head; first match wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
`ifdef STB_FWD_EN
        youngest = '0;
`endif
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            idx = wr_ptr[IW-1:0] - IW'(k);
            if (!hit && (k <= 32'(count)) && entries[idx].valid &&
                (entries[idx].waddr == load_waddr)) begin
                hit = 1'b1;
`ifdef STB_FWD_EN
                youngest = idx;
`endif
            end
        end
    end

`ifdef STB_FWD_EN
    assign match_idx = youngest;
    assign fwd_ok    = hit & (&entries[youngest].be);
`else
    assign fwd_ok    = 1'b0;
`endif

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the MEM stage and data memory.
// Stores enqueue in one cycle and drain in order over a valid/ready port;
// loads read memory directly and stall on a buffered-address hazard.
// Optional macro STB_FWD_EN: forward full-word data from the youngest match.
module store_buffer
    import stb_pkg::*;
#(
    parameter int DEPTH = STB_DEPTH,
    parameter int AW    = STB_AW,
    parameter int DW    = STB_DW
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave bus
);

    localparam int IW = $clog2(DEPTH);

    stb_entry_t    entries [DEPTH];
    logic [IW:0]   wr_ptr;
    logic [IW:0]   rd_ptr;
    stb_entry_t    head;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          hit;
    logic          load_hit;
    logic          fwd_ok;
`ifdef STB_FWD_EN
    logic [IW-1:0] match_idx;
`endif

    stb_match #(.DEPTH(DEPTH)) u_match (
        .entries    (entries),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .load_waddr (word_addr(bus.cpu_addr)),
        .hit        (hit),
`ifdef STB_FWD_EN
        .match_idx  (match_idx),
`endif
        .fwd_ok     (fwd_ok)
    );

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    assign load_hit = bus.cpu_re & hit;

    // Full is judged on registered state, so a same-cycle pop does not admit a store.
    assign bus.stall_o = (bus.cpu_we & full) | (load_hit & ~fwd_ok) | (bus.cpu_fence & ~empty);

    assign push = bus.cpu_we & ~bus.stall_o;
    assign pop  = ~empty & bus.mem_wready;

    assign head      = entries[rd_ptr[IW-1:0]];
    assign head_addr = AW'({head.waddr, 2'b00});
    assign head_data = head.data;

    assign bus.mem_raddr  = bus.cpu_addr;
    assign bus.mem_wvalid = ~empty;
    assign bus.mem_waddr  = empty ? '0 : head_addr;
    assign bus.mem_wdata  = empty ? '0 : head_data;
    assign bus.mem_wbe    = empty ? '0 : head.be;

`ifdef STB_FWD_EN
    assign bus.cpu_rdata = (load_hit & fwd_ok) ? entries[match_idx].data : bus.mem_rdata;
`else
    assign bus.cpu_rdata = bus.mem_rdata;
`endif

    // FIFO state: enqueue at the tail, retire the head on a write handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            if (push) begin
                entries[wr_ptr[IW-1:0]] <= '{valid: 1'b1,
                                             waddr: word_addr(bus.cpu_addr),
                                             data:  bus.cpu_wdata,
                                             be:    bus.cpu_be};
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                entries[rd_ptr[IW-1:0]].valid <= 1'b0;
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule
